// File: rtl/shift_issue_stage_pkg.sv
// Shared definitions for the shift issue stage: op codes, FIFO entry layout and a fill-mask helper.
package shift_issue_stage_pkg;

    typedef enum logic [2:0] {
        OP_SHLL  = 3'b000,
        OP_SHRL  = 3'b001,
        OP_SHRA  = 3'b010,
        OP_SHLLV = 3'b011,
        OP_SHRLV = 3'b100,
        OP_SHRAV = 3'b101
    } shift_op_e;

    // Entry layout, LSB first: ILL, RD, CARRY, FILL, SHAMT, DIR, I
    localparam int OFF_ILL   = 0;
    localparam int OFF_RD    = 1;
    localparam int OFF_CARRY = 6;
    localparam int OFF_FILL  = 7;
    localparam int OFF_SHAMT = 39;
    localparam int OFF_DIR   = 44;
    localparam int OFF_I     = 45;
    localparam int ENTRY_W   = 77;

    function automatic logic [31:0] sign_fill_mask(input logic [4:0] shamt);
        return ~(32'hFFFF_FFFF >> shamt);
    endfunction

endpackage

// File: rtl/shift_issue_stage_if.sv
// Decode-side and shifter-side handshake bundle of the shift issue stage, plus the branch flush.
interface shift_issue_stage_if;

    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_rs;
    logic [31:0] in_rt;
    logic [4:0]  in_imm;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_i;
    logic        out_dir;
    logic [4:0]  out_shamt;
    logic [31:0] out_fill;
    logic        out_carry;
    logic [4:0]  out_rd;
    logic        out_ill;

    modport slave (
        input  flush, in_valid, in_op, in_rs, in_rt, in_imm, in_rd, out_ready,
        output in_ready, out_valid, out_i, out_dir, out_shamt, out_fill, out_carry, out_rd, out_ill
    );

    modport master (
        output flush, in_valid, in_op, in_rs, in_rt, in_imm, in_rd, out_ready,
        input  in_ready, out_valid, out_i, out_dir, out_shamt, out_fill, out_carry, out_rd, out_ill
    );

endinterface

// File: rtl/shift_issue_stage_fifo.sv
// Generic DEPTH x W FIFO with occupancy count and synchronous flush; DEPTH must be a power of two.
module shift_fifo #(
    parameter int DEPTH = 2,
    parameter int AW    = 1,
    parameter int W     = 77
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_wdata,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wptr] <= i_wdata;
    end

endmodule

// File: rtl/shift_issue_stage.sv
// Issue stage ahead of the barrel shifter: decodes shift micro-ops at push time and buffers them.
module shift_issue_stage
    import shift_issue_stage_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    shift_issue_stage_if.slave bus
);

    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [ENTRY_W-1:0] w_wdata;
    logic [ENTRY_W-1:0] w_rdata;
    logic [ENTRY_W-1:0] w_head;
    logic               w_imm_op;
    logic               w_left;
    logic               w_sra;
    logic               w_ill;
    logic [4:0]         w_shamt;
    logic [4:0]         w_cidx;
    logic               w_carry;
    logic [31:0]        w_fill;
    logic               w_unused;

    assign w_unused = ^bus.in_rt[31:5];

    always_comb begin
        w_imm_op = 1'b0;
        w_left   = 1'b0;
        w_sra    = 1'b0;
        w_ill    = 1'b0;
        case (bus.in_op)
            OP_SHLL:  begin w_imm_op = 1'b1; w_left = 1'b1; end
            OP_SHRL:  w_imm_op = 1'b1;
            OP_SHRA:  begin w_imm_op = 1'b1; w_sra = 1'b1; end
            OP_SHLLV: w_left = 1'b1;
            OP_SHRLV: w_left = 1'b0;
            OP_SHRAV: w_sra = 1'b1;
            default:  w_ill = 1'b1;
        endcase
    end

    // Carry index: left shifts lose bit 32-SHAMT, right shifts lose bit SHAMT-1.
    always_comb begin
        w_shamt = w_ill ? 5'd0 : (w_imm_op ? bus.in_imm : bus.in_rt[4:0]);
        w_cidx  = w_left ? 5'(6'd32 - {1'b0, w_shamt}) : (w_shamt - 5'd1);
        w_carry = (w_shamt != 5'd0) && bus.in_rs[w_cidx];
        w_fill  = (w_sra && bus.in_rs[31]) ? sign_fill_mask(w_shamt) : 32'd0;
    end

    always_comb begin
        w_wdata                   = '0;
        w_wdata[OFF_I +: 32]      = bus.in_rs;
        w_wdata[OFF_DIR]          = w_left;
        w_wdata[OFF_SHAMT +: 5]   = w_shamt;
        w_wdata[OFF_FILL +: 32]   = w_fill;
        w_wdata[OFF_CARRY]        = w_carry;
        w_wdata[OFF_RD +: 5]      = bus.in_rd;
        w_wdata[OFF_ILL]          = w_ill;
    end

    assign bus.in_ready  = !w_full;
    assign bus.out_valid = !w_empty;
    assign w_push        = bus.in_valid && !w_full;
    assign w_pop         = !w_empty && bus.out_ready;

    shift_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (bus.flush),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Storage is not reset, so the head is forced to zero whenever nothing is buffered.
    assign w_head        = w_empty ? '0 : w_rdata;
    assign bus.out_i     = w_head[OFF_I +: 32];
    assign bus.out_dir   = w_head[OFF_DIR];
    assign bus.out_shamt = w_head[OFF_SHAMT +: 5];
    assign bus.out_fill  = w_head[OFF_FILL +: 32];
    assign bus.out_carry = w_head[OFF_CARRY];
    assign bus.out_rd    = w_head[OFF_RD +: 5];
    assign bus.out_ill   = w_head[OFF_ILL];

endmodule

// File: tb/tb_shift_issue_stage.sv
// Randomized and directed bench for shift_issue_stage against a queue-based behavioural model.
module tb_shift_issue_stage;

    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] i;
        logic        dir;
        logic [4:0]  shamt;
        logic [31:0] fill;
        logic        carry;
        logic [4:0]  rd;
        logic        ill;
    } expEntry_t;

    logic clk;
    logic rst_n;
    int   compareCount;
    int   failCount;
    expEntry_t modelQ[$];

    shift_issue_stage_if bus ();

    shift_issue_stage #(
        .DEPTH (DEPTH),
        .AW    (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected decode straight from the op table, using wide shifts for the lost bit.
    function automatic expEntry_t predict(input logic [2:0] op, input logic [31:0] rs,
                                          input logic [31:0] rt, input logic [4:0] imm,
                                          input logic [4:0] rd);
        expEntry_t e;
        int amt;
        logic [63:0] wide;
        e.i = rs;
        e.rd = rd;
        e.ill = (op > 3'd5);
        e.dir = 1'b0;
        e.shamt = 5'd0;
        e.fill = 32'd0;
        e.carry = 1'b0;
        if (!e.ill) begin
            amt = (op < 3'd3) ? int'(imm) : int'(rt % 32);
            e.shamt = 5'(amt);
            e.dir = (op == 3'd0 || op == 3'd3);
            if ((op == 3'd2 || op == 3'd5) && rs[31]) begin
                for (int k = 0; k < amt; k++) e.fill[31-k] = 1'b1;
            end
            if (amt != 0) begin
                if (e.dir) begin
                    wide = {32'd0, rs} << amt;
                    e.carry = wide[32];
                end else begin
                    wide = {rs, 32'd0} >> amt;
                    e.carry = wide[31];
                end
            end
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compareCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit valid, input logic [2:0] op, input logic [31:0] rs,
                                 input logic [31:0] rt, input logic [4:0] imm, input logic [4:0] rd,
                                 input bit outReady, input bit flush);
        bus.in_valid  = valid;
        bus.in_op     = op;
        bus.in_rs     = rs;
        bus.in_rt     = rt;
        bus.in_imm    = imm;
        bus.in_rd     = rd;
        bus.out_ready = outReady;
        bus.flush     = flush;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit outReady);
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 5'd0, outReady, 1'b0);
    endtask

    // Model advances on the same edge as the DUT, using only bench-driven inputs.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            modelQ.delete();
        end else if (bus.flush) begin
            modelQ.delete();
        end else begin
            bit doPush;
            bit doPop;
            doPush = bus.in_valid && (modelQ.size() < DEPTH);
            doPop  = bus.out_ready && (modelQ.size() > 0);
            if (doPop) void'(modelQ.pop_front());
            if (doPush) modelQ.push_back(predict(bus.in_op, bus.in_rs, bus.in_rt, bus.in_imm, bus.in_rd));
        end
    end

    always @(negedge clk) begin
        expEntry_t h;
        checkOutput("in_ready", 32'(bus.in_ready), 32'(modelQ.size() != DEPTH));
        checkOutput("out_valid", 32'(bus.out_valid), 32'(modelQ.size() != 0));
        if (modelQ.size() != 0) h = modelQ[0];
        else h = '{32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0};
        checkOutput("out_i", bus.out_i, h.i);
        checkOutput("out_dir", 32'(bus.out_dir), 32'(h.dir));
        checkOutput("out_shamt", 32'(bus.out_shamt), 32'(h.shamt));
        checkOutput("out_fill", bus.out_fill, h.fill);
        checkOutput("out_carry", 32'(bus.out_carry), 32'(h.carry));
        checkOutput("out_rd", 32'(bus.out_rd), 32'(h.rd));
        checkOutput("out_ill", 32'(bus.out_ill), 32'(h.ill));
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        compareCount = 0;
        failCount = 0;
        rst_n = 1'b1;
        bus.in_valid = 1'b0; bus.in_op = 3'd0; bus.in_rs = 32'd0; bus.in_rt = 32'd0;
        bus.in_imm = 5'd0; bus.in_rd = 5'd0; bus.out_ready = 1'b0; bus.flush = 1'b0;
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1'b0);

        // SHLL 8000_0001 by 1
        applyStimulus(1'b1, 3'b000, 32'h8000_0001, 32'd0, 5'd1, 5'd3, 1'b0, 1'b0);
        checkOutput("shll_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("shll_dir", 32'(bus.out_dir), 32'd1);
        checkOutput("shll_shamt", 32'(bus.out_shamt), 32'd1);
        checkOutput("shll_carry", 32'(bus.out_carry), 32'd1);
        checkOutput("shll_fill", bus.out_fill, 32'd0);
        idle(1'b1);

        // SHRAV F000_0000 by rt=0x24
        applyStimulus(1'b1, 3'b101, 32'hF000_0000, 32'h24, 5'd0, 5'd7, 1'b0, 1'b0);
        checkOutput("srav_shamt", 32'(bus.out_shamt), 32'd4);
        checkOutput("srav_dir", 32'(bus.out_dir), 32'd0);
        checkOutput("srav_fill", bus.out_fill, 32'hF000_0000);
        checkOutput("srav_carry", 32'(bus.out_carry), 32'd0);
        idle(1'b1);

        // Back-pressure: third op held while full, order preserved
        applyStimulus(1'b1, 3'b001, 32'hAAAA_0001, 32'd0, 5'd2, 5'd1, 1'b0, 1'b0);
        checkOutput("bp_ready_after1", 32'(bus.in_ready), 32'd1);
        applyStimulus(1'b1, 3'b001, 32'hBBBB_0002, 32'd0, 5'd3, 5'd2, 1'b0, 1'b0);
        checkOutput("bp_ready_after2", 32'(bus.in_ready), 32'd0);
        applyStimulus(1'b1, 3'b001, 32'hCCCC_0003, 32'd0, 5'd4, 5'd3, 1'b0, 1'b0);
        checkOutput("bp_head_held", bus.out_i, 32'hAAAA_0001);
        applyStimulus(1'b1, 3'b001, 32'hCCCC_0003, 32'd0, 5'd4, 5'd3, 1'b1, 1'b0);
        checkOutput("bp_head_second", bus.out_i, 32'hBBBB_0002);
        applyStimulus(1'b1, 3'b001, 32'hCCCC_0003, 32'd0, 5'd4, 5'd3, 1'b1, 1'b0);
        checkOutput("bp_head_third", bus.out_i, 32'hCCCC_0003);
        idle(1'b1);
        checkOutput("bp_drained", 32'(bus.out_valid), 32'd0);

        // Push+pop at empty: only the push takes effect
        applyStimulus(1'b1, 3'b011, 32'h0000_00F0, 32'd8, 5'd0, 5'd9, 1'b1, 1'b0);
        checkOutput("empty_pushpop_valid", 32'(bus.out_valid), 32'd1);
        // Flush in the same cycle as a push
        applyStimulus(1'b1, 3'b000, 32'h1234_5678, 32'd0, 5'd5, 5'd4, 1'b0, 1'b1);
        checkOutput("flush_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("flush_ready", 32'(bus.in_ready), 32'd1);

        // Illegal op 111
        applyStimulus(1'b1, 3'b111, 32'h1234_5678, 32'd9, 5'd7, 5'd6, 1'b0, 1'b0);
        checkOutput("ill_flag", 32'(bus.out_ill), 32'd1);
        checkOutput("ill_shamt", 32'(bus.out_shamt), 32'd0);
        checkOutput("ill_i", bus.out_i, 32'h1234_5678);
        applyStimulus(1'b1, 3'b010, 32'h8000_0000, 32'd0, 5'd31, 5'd8, 1'b0, 1'b0);

        // Asynchronous reset with two entries buffered
        checkOutput("prereset_full", 32'(bus.in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midreset_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("midreset_i", bus.out_i, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1'b0);

        for (int n = 0; n < 600; n++) begin
            applyStimulus(1'($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)), $urandom, $urandom,
                          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 24) == 0));
        end
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
